// File: rtl/wb_trace_checker.sv
// wb_trace_checker: checks debug_wb_* retirements against a golden trace FIFO.
// Optional feature macro TRACE_TIMEOUT_EN: fail after TIMEOUT idle RUN cycles.
// Ports: clk, rst_n (sync, active low), start pulse; wb_* retirement port;
//   gold_* golden stream (valid/ready, gold_last marks final entry);
//   pass/fail sticky result, err_code/err_pc/err_got/err_exp first-error
//   capture, inst_count retirements checked (saturating).
module wb_trace_checker #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
`ifdef TRACE_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 1024
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             wb_have_inst,
  input  logic [31:0]      wb_pc,
  input  logic             wb_ena,
  input  logic [4:0]       wb_reg,
  input  logic [31:0]      wb_value,
  input  logic             gold_valid,
  output logic             gold_ready,
  input  logic [31:0]      gold_pc,
  input  logic             gold_ena,
  input  logic [4:0]       gold_reg,
  input  logic [31:0]      gold_value,
  input  logic             gold_last,
  output logic             pass,
  output logic             fail,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] inst_count,
  output logic [31:0]      err_pc,
  output logic [31:0]      err_got,
  output logic [31:0]      err_exp
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_PC    = 3'd1;
  localparam logic [2:0] E_ENA   = 3'd2;
  localparam logic [2:0] E_REG   = 3'd3;
  localparam logic [2:0] E_VAL   = 3'd4;
  localparam logic [2:0] E_UNDER = 3'd5;
  localparam logic [2:0] E_TMO   = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        ena;
    logic [4:0]  rg;
    logic [31:0] val;
    logic        last;
  } ent_t;

  state_t           state_q, state_d;
  ent_t             mem_q [DEPTH];
  ent_t             head;
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0] inst_q, inst_d;
  logic [2:0]       code_q, code_d, code;
  logic [31:0]      epc_q, epc_d, got_q, got_d, exp_q, exp_d;
  logic             empty, push, pop, check, g_en, c_en, tmo;

`ifdef TRACE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] idle_q, idle_d;
  logic          idle_cyc;

  // Counts RUN cycles without a retirement; zero elsewhere, so IDLE->RUN
  // and every checked retirement restart it.
  always_comb begin
    idle_cyc = (state_q == S_RUN) && !wb_have_inst;
    idle_d   = idle_cyc ? idle_q + 1'b1 : '0;
    tmo      = idle_cyc && (idle_q == TMO_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    head  = mem_q[rd_q];
    empty = (cnt_q == '0);
    gold_ready = ((state_q == S_IDLE) || (state_q == S_RUN)) &&
                 (cnt_q != FULL);
    push  = gold_valid && gold_ready;
    check = (state_q == S_RUN) && wb_have_inst;
    pop   = check && !empty;
    // A write to x0 is discarded, so treat it as no write on both sides.
    g_en  = head.ena && (head.rg != '0);
    c_en  = wb_ena && (wb_reg != '0);
    if (empty)                         code = E_UNDER;
    else if (wb_pc != head.pc)         code = E_PC;
    else if (g_en != c_en)             code = E_ENA;
    else if (g_en && wb_reg != head.rg)    code = E_REG;
    else if (g_en && wb_value != head.val) code = E_VAL;
    else                               code = E_NONE;
  end

  always_comb begin
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop  ? rd_q + 1'b1 : rd_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    state_d = state_q;
    inst_d  = inst_q;
    code_d  = code_q;
    epc_d   = epc_q;
    got_d   = got_q;
    exp_d   = exp_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (check) begin
          if (inst_q != '1) inst_d = inst_q + 1'b1;
          if (code != E_NONE) begin
            state_d = S_FAIL;
            code_d  = code;
            epc_d   = wb_pc;
            // Underrun has no golden entry; data captures stay zero.
            if (!empty) begin
              got_d = wb_value;
              exp_d = head.val;
            end
          end else if (head.last) begin
            state_d = S_PASS;
          end
        end else if (tmo) begin
          state_d = S_FAIL;
          code_d  = E_TMO;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      inst_q  <= '0;
      code_q  <= E_NONE;
      epc_q   <= '0;
      got_q   <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
      got_q   <= got_d;
      exp_q   <= exp_d;
    end
  end

  // Storage needs no reset: an empty count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_q] <= {gold_pc, gold_ena, gold_reg, gold_value, gold_last};
  end

  assign pass       = (state_q == S_PASS);
  assign fail       = (state_q == S_FAIL);
  assign err_code   = code_q;
  assign inst_count = inst_q;
  assign err_pc     = epc_q;
  assign err_got    = got_q;
  assign err_exp    = exp_q;

endmodule
